// File: rtl/pzbcm_slicer_arbiter_pkg.sv
// Shared types and helpers for the slicer arbiter: state enum, round-robin
// one-hot select and one-hot to index conversion sized for up to 32 requesters.
package pzbcm_slicer_arbiter_pkg;

  localparam int MAX_N    = 32;
  localparam int MAX_ID_W = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // First valid requester strictly above ptr, wrapping at n-1 -> 0; ptr itself is checked last.
  function automatic logic [MAX_N-1:0] rr_select(
    input logic [MAX_N-1:0]    valid,
    input logic [MAX_ID_W-1:0] ptr,
    input int                  n
  );
    logic [MAX_N-1:0]    oh;
    logic                found;
    logic [MAX_ID_W-1:0] idx;
    oh    = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_N; i++) begin
      if (i <= n) begin
        idx = MAX_ID_W'((int'(ptr) + i) % n);
        if (!found && valid[idx]) begin
          oh[idx] = 1'b1;
          found   = 1'b1;
        end
      end
    end
    return oh;
  endfunction

  function automatic logic [MAX_ID_W-1:0] onehot_to_index(input logic [MAX_N-1:0] oh);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | MAX_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pzbcm_slicer_unit.sv
// Single-entry valid/ready register slice. With FULL_BANDWIDTH the entry can
// be refilled in the same cycle it drains, giving one transfer per cycle.
module pzbcm_slicer_unit #(
  parameter int WIDTH          = 1,
  parameter int FULL_BANDWIDTH = 1,
  parameter int DISABLE_MBFF   = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_load;

  assign o_ready = (FULL_BANDWIDTH != 0) ? (!r_valid || i_ready) : !r_valid;
  assign w_load  = i_valid && o_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_valid <= 1'b0;
    else if (w_load) r_valid <= 1'b1;
    else if (i_ready) r_valid <= 1'b0;
  end

  // Per-bit flops keep synthesis from packing the data register into multi-bit cells.
  if (DISABLE_MBFF != 0) begin : g_sbff
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_data[b] <= 1'b0;
        else if (w_load) r_data[b] <= i_data[b];
      end
    end
  end else begin : g_mbff
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)    r_data <= '0;
      else if (w_load) r_data <= i_data;
    end
  end

endmodule

// File: rtl/pzbcm_slicer_arbiter.sv
// N:1 round-robin arbiter with packet lock feeding one full-bandwidth register
// slice; the slice carries payload, last flag and source index.
module pzbcm_slicer_arbiter
  import pzbcm_slicer_arbiter_pkg::*;
#(
  parameter int  N            = 2,
  parameter int  WIDTH        = 1,
  parameter int  ENABLE_LOCK  = 1,
  parameter int  DISABLE_MBFF = 0,
  localparam int ID_WIDTH     = $clog2(N)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N-1:0]        i_valid,
  output logic [N-1:0]        o_ready,
  input  logic [N*WIDTH-1:0]  i_data,
  input  logic [N-1:0]        i_last,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [WIDTH-1:0]    o_data,
  output logic                o_last,
  output logic [ID_WIDTH-1:0] o_id
);

  localparam int SW = WIDTH + 1 + ID_WIDTH;

  state_e              r_state;
  state_e              w_state_next;
  logic [ID_WIDTH-1:0] r_ptr;
  logic [ID_WIDTH-1:0] r_lock_id;
  logic [MAX_N-1:0]    w_rr_oh;
  logic [ID_WIDTH-1:0] w_rr_id;
  logic [ID_WIDTH-1:0] w_gnt_id;
  logic                w_gnt_valid;
  logic                w_gnt_req;
  logic                w_gnt_last;
  logic [WIDTH-1:0]    w_gnt_data;
  logic                w_slice_valid;
  logic                w_slice_ready;
  logic                w_accept;
  logic [SW-1:0]       w_slice_in;
  logic [SW-1:0]       w_slice_out;

  // Idle grant depends only on the pointer and i_valid, so it is stable under backpressure.
  assign w_rr_oh = rr_select(MAX_N'(i_valid), MAX_ID_W'(r_ptr), N);
  assign w_rr_id = ID_WIDTH'(onehot_to_index(w_rr_oh));

  always_comb begin
    w_gnt_id    = w_rr_id;
    w_gnt_valid = |w_rr_oh;
    if (r_state == ST_LOCKED) begin
      w_gnt_id    = r_lock_id;
      w_gnt_valid = 1'b1;
    end
  end

  always_comb begin
    w_gnt_req  = 1'b0;
    w_gnt_last = 1'b0;
    w_gnt_data = '0;
    o_ready    = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_id == ID_WIDTH'(i)) begin
        w_gnt_req  = i_valid[i];
        w_gnt_last = i_last[i];
        w_gnt_data = i_data[i*WIDTH +: WIDTH];
        o_ready[i] = w_gnt_valid && w_slice_ready;
      end
    end
  end

  assign w_slice_valid = w_gnt_valid && w_gnt_req;
  assign w_accept      = w_slice_valid && w_slice_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && !w_gnt_last && (ENABLE_LOCK != 0)) w_state_next = ST_LOCKED;
      ST_LOCKED: if (w_accept && w_gnt_last) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= ID_WIDTH'(N - 1);
      r_lock_id <= '0;
    end else begin
      r_state <= w_state_next;
      // Pointer only moves at packet boundaries so a locked packet cannot shift priority.
      if (w_accept && (w_state_next == ST_IDLE)) r_ptr <= w_gnt_id;
      if (w_accept && (r_state == ST_IDLE))      r_lock_id <= w_gnt_id;
    end
  end

  assign w_slice_in = {w_gnt_id, w_gnt_last, w_gnt_data};

  pzbcm_slicer_unit #(
    .WIDTH          (SW),
    .FULL_BANDWIDTH (1),
    .DISABLE_MBFF   (DISABLE_MBFF)
  ) u_slicer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (w_slice_valid),
    .o_ready (w_slice_ready),
    .i_data  (w_slice_in),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (w_slice_out)
  );

  assign {o_id, o_last, o_data} = w_slice_out;

endmodule
